tx_payload_sequencer: RTL and testbench

Parametrised successor to the Ethernet TX memory controller. Per packet, it generates the VRAM pixel read-address stream and serialises pixels into payload bytes under valid/ready backpressure. A per-segment start-address table lets redundant copies (`txid` > 1) replay exactly the pixels sent by `txid` == 1. It sits between the VRAM read port and the UDP/MAC byte framer in the 125 MHz domain.

---
 rtl/tx_payload_sequencer_pkg.sv | 29 ++
 rtl/tx_payload_sequencer_if.sv | 21 ++
 rtl/tx_payload_sequencer_skid_fifo.sv | 64 ++++++
 rtl/tx_payload_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_tx_payload_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/tx_payload_sequencer_pkg.sv
// Shared types and defaults for the TX payload sequencer.
// State encoding, width helper and default framing constants.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN
  } state_e;

  localparam int BPP_DEF              = 3;
  localparam int PAYLOAD_BYTES_DEF    = 1440;
  localparam int PIXELS_PER_FRAME_DEF = 57600;

  // Returns at least 1 so that it can size counters for tiny values.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tx_payload_sequencer_if.sv
// Payload byte stream towards the UDP/MAC framer.
// Valid/ready handshake, one byte per transfer.
interface tx_payload_sequencer_if;

  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );

endinterface

// File: rtl/tx_payload_sequencer_skid_fifo.sv
// Small skid FIFO that absorbs VRAM reads still in flight
// when the byte stream stalls; exports its free-entry count.
module tx_skid_fifo
  import tx_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [W-1:0]                din,
  input  logic                        pop,
  output logic [W-1:0]                dout,
  output logic                        empty,
  output logic [clog2(DEPTH+1)-1:0]   free
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = din;
      wp_d        = inc(wp_q);
    end
    if (pop) rp_d = inc(rp_q);
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rp_q];
  assign empty = (cnt_q == '0);
  assign free  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/tx_payload_sequencer.sv
// Per-packet VRAM read sequencer and pixel-to-byte serialiser
// with a segment start table so redundant copies replay pixels.
module tx_payload_sequencer
  import tx_pkg::*;
#(
  parameter int BPP              = BPP_DEF,
  parameter int PIXELS_PER_FRAME = PIXELS_PER_FRAME_DEF,
  parameter int PAYLOAD_BYTES    = PAYLOAD_BYTES_DEF,
  parameter int SEG_MAX          = 128,
  parameter int ADDR_W           = 16,
  parameter int RAM_LAT          = 2
) (
  input  logic                  clk125MHz,
  input  logic                  rst_n,
  input  logic                  pkt_start,
  input  logic [7:0]            txid,
  input  logic [15:0]           segment_num,
  input  logic [7:0]            redundancy,
  input  logic [15:0]           segment_num_max,
  output logic [ADDR_W-1:0]     vram_addr,
  input  logic [8*BPP-1:0]      vram_data,
  tx_payload_sequencer_if.master bs,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [ADDR_W-1:0]     startaddr,
  output logic                  oneframe_done,
  output logic                  err_seg
);

  if (PAYLOAD_BYTES % BPP != 0) begin : g_bad_payload
    $error("PAYLOAD_BYTES must be a multiple of BPP");
  end

  localparam int NPIX  = PAYLOAD_BYTES / BPP;
  localparam int CNT_W = clog2(NPIX + 1);
  localparam int SEG_W = clog2(SEG_MAX);
  localparam int DEPTH = RAM_LAT + 2;
  localparam int FW    = clog2(DEPTH + 1);
  localparam int BW    = clog2(BPP);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS_PER_FRAME - 1);

  state_e              state_q, state_d;
  logic [7:0]          txid_q, txid_d;
  logic [15:0]         seg_q, seg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]   fp_q, fp_d;
  logic                fwrap_q, fwrap_d;
  logic                pwrap_q, pwrap_d;
  logic [SEG_MAX-1:0]  valid_q, valid_d;
  logic                err_q, err_d;
  logic [RAM_LAT-1:0]  pipe_q, pipe_d;
  logic [BW-1:0]       bidx_q, bidx_d;
  logic [ADDR_W-1:0]   tbl_q [SEG_MAX];

  logic                tbl_we, rd_en, hs, last, done, frame_end, replay;
  logic                fifo_pop, fifo_empty;
  logic [8*BPP-1:0]    fifo_dout;
  logic [FW-1:0]       fifo_free;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W:0]     fp_sum;
  logic [SEG_W-1:0]    seg_in, seg_idx;
  logic                seg_oob;

  assign seg_in  = segment_num[SEG_W-1:0];
  assign seg_idx = seg_q[SEG_W-1:0];
  assign seg_oob = int'(segment_num) >= SEG_MAX;
  assign replay  = txid_q > 8'd1;

  // A read may issue only if the FIFO can absorb it plus all in flight.
  assign rd_en    = (state_q == STREAM) && (fifo_free >= FW'(RAM_LAT + 1));
  assign pipe_d   = (pipe_q << 1) | RAM_LAT'(rd_en);
  assign hs       = bs.byte_valid && bs.byte_ready;
  assign fifo_pop = hs && (bidx_q == BW'(BPP - 1));
  assign bidx_d   = !hs ? bidx_q : (fifo_pop ? '0 : bidx_q + 1'b1);

  // Last byte: no reads left or in flight, one word left, its final byte.
  assign last = (state_q == DRAIN) && (pipe_q == '0) &&
                (fifo_free == FW'(DEPTH - 1)) &&
                (bidx_q == BW'(BPP - 1));
  assign done = hs && last;
  assign frame_end = done &&
    ((redundancy == 8'd1 && pwrap_q) ||
     (fwrap_q && txid_q >= redundancy &&
      seg_q == segment_num_max - 16'd1));

  always_comb begin
    state_d  = state_q;
    txid_d   = txid_q;
    seg_d    = seg_q;
    addr_d   = addr_q;
    start_d  = start_q;
    rd_cnt_d = rd_cnt_q;
    fp_d     = fp_q;
    fwrap_d  = fwrap_q;
    pwrap_d  = pwrap_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    tbl_we   = 1'b0;
    base     = fp_q;
    fp_sum   = {1'b0, fp_q} + (ADDR_W + 1)'(NPIX);
    if (fp_sum >= (ADDR_W + 1)'(PIXELS_PER_FRAME))
      fp_sum = fp_sum - (ADDR_W + 1)'(PIXELS_PER_FRAME);
    unique case (state_q)
      IDLE: if (pkt_start) begin
        if (seg_oob || (txid > 8'd1 && !valid_q[seg_in])) begin
          err_d = 1'b1;
        end else begin
          txid_d  = txid;
          seg_d   = segment_num;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (replay) begin
          base = tbl_q[seg_idx];
        end else begin
          tbl_we           = 1'b1;
          valid_d[seg_idx] = 1'b1;
        end
        start_d  = base;
        addr_d   = base;
        rd_cnt_d = '0;
        pwrap_d  = 1'b0;
        state_d  = STREAM;
      end
      STREAM: if (rd_en) begin
        addr_d = (addr_q == LAST_PIX) ? '0 : addr_q + 1'b1;
        if (addr_q == LAST_PIX) begin
          pwrap_d = 1'b1;
          if (!replay) fwrap_d = 1'b1;
        end
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == CNT_W'(NPIX - 1)) state_d = DRAIN;
      end
      DRAIN: if (done) begin
        state_d = IDLE;
        if (!replay) fp_d = fp_sum[ADDR_W-1:0];
        if (frame_end) begin
          fp_d    = '0;
          fwrap_d = 1'b0;
          valid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      txid_q   <= '0;
      seg_q    <= '0;
      addr_q   <= '0;
      start_q  <= '0;
      rd_cnt_q <= '0;
      fp_q     <= '0;
      fwrap_q  <= 1'b0;
      pwrap_q  <= 1'b0;
      valid_q  <= '0;
      err_q    <= 1'b0;
      pipe_q   <= '0;
      bidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      txid_q   <= txid_d;
      seg_q    <= seg_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      rd_cnt_q <= rd_cnt_d;
      fp_q     <= fp_d;
      fwrap_q  <= fwrap_d;
      pwrap_q  <= pwrap_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      pipe_q   <= pipe_d;
      bidx_q   <= bidx_d;
    end
  end

  always_ff @(posedge clk125MHz) begin
    if (tbl_we) tbl_q[seg_idx] <= fp_q;
  end

  tx_skid_fifo #(
    .W     (8 * BPP),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk125MHz),
    .rst_n (rst_n),
    .push  (pipe_q[RAM_LAT-1]),
    .din   (vram_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  assign bs.byte_valid = !fifo_empty;
  assign bs.byte_data  =
    8'(fifo_dout >> (8 * (BPP - 1 - int'(bidx_q))));

  assign vram_addr     = addr_q;
  assign startaddr     = start_q;
  assign busy          = (state_q != IDLE);
  assign pkt_done      = done;
  assign oneframe_done = frame_end;
  assign err_seg       = err_q;

endmodule

// File: tb/tb_tx_payload_sequencer.sv
// Directed bench for tx_payload_sequencer with a 1000-pixel frame
// and a two-cycle VRAM model returning an address-derived pattern.
module tb_tx_payload_sequencer;

  localparam int PPF  = 1000;
  localparam int NB   = 1440;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_start = 1'b0;
  logic [7:0]  txid = 8'd0;
  logic [15:0] segment_num = 16'd0;
  logic [7:0]  redundancy = 8'd2;
  logic [15:0] segment_num_max = 16'd3;
  logic [15:0] vram_addr;
  logic [23:0] vram_data;
  logic        busy, pkt_done, oneframe_done, err_seg;
  logic [15:0] startaddr;
  logic [15:0] a1, a2;

  int checks = 0;
  int failures = 0;
  int nof;

  tx_payload_sequencer_if bs();

  tx_payload_sequencer #(
    .PIXELS_PER_FRAME (PPF)
  ) dut (
    .clk125MHz       (clk),
    .rst_n           (rst_n),
    .pkt_start       (pkt_start),
    .txid            (txid),
    .segment_num     (segment_num),
    .redundancy      (redundancy),
    .segment_num_max (segment_num_max),
    .vram_addr       (vram_addr),
    .vram_data       (vram_data),
    .bs              (bs),
    .busy            (busy),
    .pkt_done        (pkt_done),
    .startaddr       (startaddr),
    .oneframe_done   (oneframe_done),
    .err_seg         (err_seg)
  );

  always #4 clk = ~clk;

  function automatic logic [23:0] pix(input logic [15:0] a);
    return {a[7:0], a[15:8] ^ 8'h3C, a[7:0] + 8'h11};
  endfunction

  always @(posedge clk) begin
    a1 <= vram_addr;
    a2 <= a1;
  end
  assign vram_data = pix(a2);

  function automatic logic [7:0] exp_byte(input int base, input int k);
    logic [23:0] p;
    p = pix(16'((base + k / 3) % PPF));
    case (k % 3)
      0:       return p[23:16];
      1:       return p[15:8];
      default: return p[7:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pkt(input int tx, input int seg, input int base,
                         input bit rnd, input int abort_at,
                         output int of_cnt);
    int k = 0;
    int cyc = 0;
    int ndone = 0;
    int nerr = 0;
    logic stalled = 1'b0;
    logic [7:0] pd = 8'd0;
    of_cnt = 0;
    @(negedge clk);
    txid = 8'(tx);
    segment_num = 16'(seg);
    pkt_start = 1'b1;
    while (k < NB && cyc < 8000 && !(abort_at > 0 && k == abort_at)) begin
      @(negedge clk);
      cyc++;
      pkt_start = (cyc == 10);
      segment_num = (cyc == 10) ? 16'd200 : 16'(seg);
      bs.byte_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      if (cyc == 1) chk("busy_in_load", busy, 1);
      if (stalled) chk("stall_hold", {bs.byte_valid, bs.byte_data}, {1'b1, pd});
      if (err_seg) nerr++;
      if (pkt_done) ndone++;
      if (oneframe_done) of_cnt++;
      if (bs.byte_valid && bs.byte_ready) begin
        chk("byte", bs.byte_data, exp_byte(base, k));
        if (!rnd && k == 0) chk("first_byte_cycle", cyc, 5);
        if (k == NB - 1) begin
          chk("done_on_last", pkt_done, 1);
          if (!rnd) chk("done_cycle", cyc, NB + 4);
        end
        k++;
      end
      stalled = bs.byte_valid && !bs.byte_ready;
      pd = bs.byte_data;
    end
    pkt_start = 1'b0;
    segment_num = 16'(seg);
    if (abort_at == 0) begin
      chk("byte_count", k, NB);
      chk("done_count", ndone, 1);
      chk("busy_start_ignored", nerr, 0);
      chk("startaddr", startaddr, base);
      @(negedge clk);
      #1;
      chk("idle_after_done", busy, 0);
    end
  endtask

  task automatic err_req(input int tx, input int seg, input string tag);
    @(negedge clk);
    txid = 8'(tx);
    segment_num = 16'(seg);
    pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    #1;
    chk({tag, "_pulse"}, err_seg, 1);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    #1;
    chk({tag, "_clear"}, {err_seg, busy}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {busy, bs.byte_valid, pkt_done,
                          oneframe_done, err_seg}, 0);
    chk({tag, "_vram_addr"}, vram_addr, 0);
    chk({tag, "_startaddr"}, startaddr, 0);
    chk({tag, "_byte_data"}, bs.byte_data, 0);
  endtask

  initial begin
    bs.byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    run_pkt(1, 0, 0, 1'b0, 0, nof);
    chk("of_t1s0", nof, 0);
    run_pkt(1, 1, 480, 1'b0, 0, nof);
    chk("of_t1s1", nof, 0);
    run_pkt(1, 2, 960, 1'b0, 0, nof);
    chk("of_t1s2", nof, 0);
    run_pkt(2, 1, 480, 1'b0, 0, nof);
    chk("of_t2s1", nof, 0);
    run_pkt(2, 0, 0, 1'b1, 0, nof);
    chk("of_t2s0_rand", nof, 0);

    err_req(1, 200, "seg_oob");
    err_req(2, 5, "unwritten");

    run_pkt(2, 2, 960, 1'b0, 0, nof);
    chk("of_t2s2", nof, 1);
    err_req(2, 0, "cleared_valid");
    run_pkt(1, 0, 0, 1'b0, 0, nof);
    chk("of_new_frame", nof, 0);

    run_pkt(1, 1, 480, 1'b0, 700, nof);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt(1, 0, 0, 1'b0, 0, nof);
    chk("of_after_reset", nof, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
